// File: rtl/fnd_monitor.sv
// Purpose: passive receiver for a scanned 4-digit 7-segment bus; rebuilds the shown integer.
// Latency: a value is available 5 clocks after the sample that completes a 4-digit frame.
// Backpressure: none; the monitor only observes the bus and never stalls the driver.
module fnd_monitor #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [13:0] value,
  output logic        value_valid,
  output logic [3:0]  blank_mask,
  output logic [3:0]  dp_mask,
  output logic        digit_err,
  output logic        com_err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [7:0] SETTLE_SAT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_M1  = 8'(SETTLE_CYCLES - 1);

  // registered bus and settle filter
  logic [3:0]       com_q, com_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       cnt_q, cnt_d;
  // per-slot capture
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       blank_q, blank_d;
  logic [3:0]       dp_q, dp_d;
  // frame snapshot and conversion
  logic [3:0][3:0]  snap_dig_q, snap_dig_d;
  logic [3:0]       snap_blank_q, snap_blank_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [13:0]      acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  state_t           state_q, state_d;
  // registered outputs
  logic [13:0]      value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic [3:0]       blank_mask_q, blank_mask_d;
  logic [3:0]       dp_mask_q, dp_mask_d;
  logic             digit_err_q, digit_err_d;
  logic             com_err_q, com_err_d;

  // decode helpers
  logic             pair_chg;
  logic             sample;
  logic             slot_vld;
  logic [1:0]       slot;
  logic             com_bad;
  logic             seg_ok;
  logic [3:0]       seg_dig;
  logic             seg_blank;
  logic             seg_bad;
  logic             err_now;
  logic             wr;
  logic             start;
  logic [13:0]      acc_next;

  // Settle filter, bus decode, slot capture and conversion FSM next-state logic
  always_comb begin
    com_d = fnd_com;
    dat_d = fnd_data;

    // counter restarts on any change of the registered pair and saturates once settled,
    // so a held pair produces exactly one sample
    pair_chg = ({fnd_com, fnd_data} != {com_q, dat_q});
    if (pair_chg) begin
      cnt_d = 8'd0;
    end else if (cnt_q == SETTLE_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    sample = (cnt_q == SETTLE_M1);

    slot_vld = 1'b0;
    slot     = 2'd0;
    com_bad  = 1'b0;
    case (com_q)
      4'b1110: begin slot_vld = 1'b1; slot = 2'd0; end
      4'b1101: begin slot_vld = 1'b1; slot = 2'd1; end
      4'b1011: begin slot_vld = 1'b1; slot = 2'd2; end
      4'b0111: begin slot_vld = 1'b1; slot = 2'd3; end
      4'b1111: ;  // blanking interval between digits
      default: com_bad = sample;
    endcase

    seg_ok    = 1'b1;
    seg_dig   = 4'd0;
    seg_blank = 1'b0;
    case (dat_q[6:0])
      7'h40: seg_dig = 4'd0;
      7'h79: seg_dig = 4'd1;
      7'h24: seg_dig = 4'd2;
      7'h30: seg_dig = 4'd3;
      7'h19: seg_dig = 4'd4;
      7'h12: seg_dig = 4'd5;
      7'h02: seg_dig = 4'd6;
      7'h78: seg_dig = 4'd7;
      7'h00: seg_dig = 4'd8;
      7'h10: seg_dig = 4'd9;
      7'h7F: seg_blank = 1'b1;  // dark digit counts as zero
      default: seg_ok = 1'b0;
    endcase

    seg_bad = sample & slot_vld & ~seg_ok;
    err_now = com_bad | seg_bad;
    wr      = sample & slot_vld & seg_ok;
    // an error on the same clock as a full mask wins: the frame is discarded
    start   = (state_q == IDLE) && (mask_q == 4'hF) && !err_now;

    mask_d  = start ? 4'h0 : mask_q;
    dig_d   = dig_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    if (err_now) begin
      mask_d = 4'h0;
    end else if (wr) begin
      mask_d[slot]  = 1'b1;
      dig_d[slot]   = seg_dig;
      blank_d[slot] = seg_blank;
      dp_d[slot]    = ~dat_q[7];
    end

    digit_err_d = seg_bad;
    com_err_d   = com_bad;

    state_d       = state_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    snap_dig_d    = snap_dig_q;
    snap_blank_d  = snap_blank_q;
    snap_dp_d     = snap_dp_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    blank_mask_d  = blank_mask_q;
    dp_mask_d     = dp_mask_q;
    // acc*10 + digit as (acc<<3) + (acc<<1) + digit; acc <= 999 here so nothing overflows
    acc_next = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0} + {10'd0, snap_dig_q[idx_q]};

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_dig_d   = dig_q;
          snap_blank_d = blank_q;
          snap_dp_d    = dp_q;
          acc_d        = 14'd0;
          idx_d        = 2'd3;
          state_d      = CONV;
        end
      end
      CONV: begin
        // thousands first, ones last; the last step publishes straight into the outputs
        acc_d = acc_next;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d       = DONE;
          value_d       = acc_next;
          blank_mask_d  = snap_blank_q;
          dp_mask_d     = snap_dp_q;
          value_valid_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      com_q         <= 4'd0;
      dat_q         <= 8'd0;
      cnt_q         <= 8'd0;
      mask_q        <= 4'd0;
      dig_q         <= '0;
      blank_q       <= 4'd0;
      dp_q          <= 4'd0;
      snap_dig_q    <= '0;
      snap_blank_q  <= 4'd0;
      snap_dp_q     <= 4'd0;
      acc_q         <= 14'd0;
      idx_q         <= 2'd0;
      state_q       <= IDLE;
      value_q       <= 14'd0;
      value_valid_q <= 1'b0;
      blank_mask_q  <= 4'd0;
      dp_mask_q     <= 4'd0;
      digit_err_q   <= 1'b0;
      com_err_q     <= 1'b0;
    end else begin
      com_q         <= com_d;
      dat_q         <= dat_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      dig_q         <= dig_d;
      blank_q       <= blank_d;
      dp_q          <= dp_d;
      snap_dig_q    <= snap_dig_d;
      snap_blank_q  <= snap_blank_d;
      snap_dp_q     <= snap_dp_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      blank_mask_q  <= blank_mask_d;
      dp_mask_q     <= dp_mask_d;
      digit_err_q   <= digit_err_d;
      com_err_q     <= com_err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign blank_mask  = blank_mask_q;
  assign dp_mask     = dp_mask_q;
  assign digit_err   = digit_err_q;
  assign com_err     = com_err_q;

endmodule

// File: tb/tb_fnd_monitor.sv
// Directed bench for fnd_monitor: scans hand-built frames onto the bus and
// compares reconstructed values, masks and error pulses against fixed expectations.
module tb_fnd_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic [13:0] value;
  logic        value_valid;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic        digit_err;
  logic        com_err;

  int n_cmp = 0;
  int n_bad = 0;

  int vv_cnt = 0;
  int de_cnt = 0;
  int ce_cnt = 0;
  int val_log   [32];
  int blank_log [32];
  int dp_log    [32];

  fnd_monitor #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fnd_com     (fnd_com),
    .fnd_data    (fnd_data),
    .value       (value),
    .value_valid (value_valid),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .digit_err   (digit_err),
    .com_err     (com_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (value_valid === 1'b1) begin
      val_log[vv_cnt % 32]   <= int'(value);
      blank_log[vv_cnt % 32] <= int'(blank_mask);
      dp_log[vv_cnt % 32]    <= int'(dp_mask);
      vv_cnt <= vv_cnt + 1;
    end
    if (digit_err === 1'b1) de_cnt <= de_cnt + 1;
    if (com_err === 1'b1)   ce_cnt <= ce_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive a pair and hold it for n clock edges, ending 1 time unit after the last edge
  task automatic hold(input logic [3:0] c, input logic [7:0] d, input int n);
    fnd_com  = c;
    fnd_data = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 8'hFF, n);
  endtask

  // slot0 (ones) .. slot3 (thousands), each held 8 clocks
  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    hold(4'b1110, s0, 8);
    hold(4'b1101, s1, 8);
    hold(4'b1011, s2, 8);
    hold(4'b0111, s3, 8);
  endtask

  int vv0;
  int de0;
  int ce0;

  initial begin
    rst      = 1'b1;
    fnd_com  = 4'b1111;
    fnd_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_value", int'(value), 0);
    check_eq("rst_valid", int'(value_valid), 0);
    check_eq("rst_blank", int'(blank_mask), 0);
    check_eq("rst_dp", int'(dp_mask), 0);
    check_eq("rst_derr", int'(digit_err), 0);
    check_eq("rst_cerr", int'(com_err), 0);
    rst = 1'b0;

    // 1: display 1234, precise latency on the final digit
    vv0 = vv_cnt;
    hold(4'b1110, 8'h99, 8);
    hold(4'b1101, 8'hB0, 8);
    hold(4'b1011, 8'hA4, 8);
    fnd_com  = 4'b0111;
    fnd_data = 8'hF9;
    repeat (9) @(posedge clk);
    #1;
    check_eq("t1_valid_early", int'(value_valid), 0);
    check_eq("t1_value_early", int'(value), 0);
    @(posedge clk);
    #1;
    check_eq("t1_valid", int'(value_valid), 1);
    check_eq("t1_value", int'(value), 1234);
    check_eq("t1_blank", int'(blank_mask), 0);
    check_eq("t1_dp", int'(dp_mask), 0);
    @(posedge clk);
    #1;
    check_eq("t1_valid_drop", int'(value_valid), 0);
    check_eq("t1_value_hold", int'(value), 1234);
    check_eq("t1_pulses", vv_cnt - vv0, 1);

    // 2: back-to-back frames 0, 9999, 0507
    vv0 = vv_cnt;
    scan(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    scan(8'h90, 8'h90, 8'h90, 8'h90);
    scan(8'hF8, 8'hC0, 8'h92, 8'hFF);
    idle(12);
    check_eq("t2_pulses", vv_cnt - vv0, 3);
    check_eq("t2_val0", val_log[vv0 % 32], 0);
    check_eq("t2_blank0", blank_log[vv0 % 32], 0);
    check_eq("t2_val1", val_log[(vv0 + 1) % 32], 9999);
    check_eq("t2_val2", val_log[(vv0 + 2) % 32], 507);
    check_eq("t2_blank2", blank_log[(vv0 + 2) % 32], 4'b1000);
    check_eq("t2_dp2", dp_log[(vv0 + 2) % 32], 0);

    // 3: pairs held only 3 clocks with glitches in between -> nothing sampled
    vv0 = vv_cnt;
    de0 = de_cnt;
    ce0 = ce_cnt;
    hold(4'b1110, 8'h80, 3);
    hold(4'b1100, 8'h80, 1);
    hold(4'b1101, 8'h80, 3);
    hold(4'b1001, 8'h3C, 1);
    hold(4'b1011, 8'h80, 3);
    hold(4'b0011, 8'h80, 1);
    hold(4'b0111, 8'h80, 3);
    idle(12);
    check_eq("t3_no_pulse", vv_cnt - vv0, 0);
    check_eq("t3_value_kept", int'(value), 507);
    check_eq("t3_no_derr", de_cnt - de0, 0);
    check_eq("t3_no_cerr", ce_cnt - ce0, 0);
    scan(8'hC0, 8'h80, 8'h92, 8'hA4);
    idle(12);
    check_eq("t3_pulse", vv_cnt - vv0, 1);
    check_eq("t3_value", int'(value), 2580);

    // 4: bad segment code on slot 2 drops the partial frame
    vv0 = vv_cnt;
    de0 = de_cnt;
    hold(4'b1110, 8'h90, 8);
    hold(4'b1101, 8'h90, 8);
    hold(4'b1011, 8'hFE, 8);
    check_eq("t4_derr", de_cnt - de0, 1);
    hold(4'b1011, 8'hB0, 8);
    hold(4'b0111, 8'h99, 8);
    hold(4'b1110, 8'hF9, 8);
    hold(4'b1101, 8'hA4, 8);
    idle(12);
    check_eq("t4_pulses", vv_cnt - vv0, 1);
    check_eq("t4_value", int'(value), 4321);

    // 5: illegal common clears the mask; all-off is silent; dp on slot 1
    vv0 = vv_cnt;
    de0 = de_cnt;
    ce0 = ce_cnt;
    hold(4'b1110, 8'hC0, 8);
    hold(4'b1101, 8'hC0, 8);
    hold(4'b1100, 8'hC0, 8);
    check_eq("t5_cerr", ce_cnt - ce0, 1);
    check_eq("t5_no_derr", de_cnt - de0, 0);
    hold(4'b1011, 8'hF8, 8);
    hold(4'b0111, 8'hF8, 8);
    idle(12);
    check_eq("t5_no_early_frame", vv_cnt - vv0, 0);
    check_eq("t5_off_no_cerr", ce_cnt - ce0, 1);
    hold(4'b1110, 8'hC0, 8);
    hold(4'b1101, 8'h30, 8);
    idle(12);
    check_eq("t5_pulse", vv_cnt - vv0, 1);
    check_eq("t5_value", int'(value), 7730);
    check_eq("t5_dp", int'(dp_mask), 4'b0010);
    check_eq("t5_blank", int'(blank_mask), 0);

    // 6: reset in the middle of converting 8888
    vv0 = vv_cnt;
    hold(4'b1110, 8'h80, 8);
    hold(4'b1101, 8'h80, 8);
    hold(4'b1011, 8'h80, 8);
    hold(4'b0111, 8'h80, 6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_rst_value", int'(value), 0);
    check_eq("t6_rst_dp", int'(dp_mask), 0);
    check_eq("t6_rst_valid", int'(value_valid), 0);
    rst = 1'b0;
    idle(12);
    check_eq("t6_no_pulse", vv_cnt - vv0, 0);
    check_eq("t6_value_zero", int'(value), 0);
    scan(8'hA4, 8'h99, 8'hC0, 8'hC0);
    idle(12);
    check_eq("t6_pulse", vv_cnt - vv0, 1);
    check_eq("t6_value", int'(value), 42);
    check_eq("t6_dp", int'(dp_mask), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fnd_monitor.md
Name: fnd_monitor

Overview:
Passive receiver for the 4-digit multiplexed 7-segment bus (fnd_com / fnd_data). It is the other end of the display controller's output interface.
It watches the scanned common-anode bus, filters scan transitions, decodes each segment pattern back to BCD, and assembles one 4-digit frame. A sequential BCD-to-binary converter then produces the displayed integer.
Used as an on-chip self-check or loopback monitor between the display driver and the pins, and as a bench scoreboard source.

Parameters:
SETTLE_CYCLES, 4, consecutive clocks a (fnd_com, fnd_data) pair must be held unchanged before it is sampled; legal range 2..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
fnd_com  input  4  digit commons, active-low; bit0 = ones digit, bit3 = thousands digit
fnd_data  input  8  segments, active-low; bit7 = dp, bits[6:0] = g..a
value  output  14  last assembled frame value, 0..9999
value_valid  output  1  one-cycle pulse when value updates
blank_mask  output  4  digits that were blank (fnd_data[6:0] = 7'h7F) in the last frame
dp_mask  output  4  decimal points lit (fnd_data[7] = 0) in the last frame
digit_err  output  1  one-cycle pulse: illegal segment pattern sampled
com_err  output  1  one-cycle pulse: illegal common pattern sampled

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears every output and all internal state:
  - value = 0, blank_mask = 0, dp_mask = 0, value_valid = 0, digit_err = 0, com_err = 0.
  - Capture mask = 0, stability counter = 0, FSM = IDLE.
  - Reset asserted during conversion aborts it; no value_valid is produced.
- Settle filter:
  - Inputs are registered once.
  - The stability counter clears whenever the registered pair changes, and increments (saturating) while it is unchanged.
  - Exactly one sample event fires per stable period. A pair applied before edge k and held is sampled at edge k+SETTLE_CYCLES.
  - A pair held indefinitely is sampled once only; re-sampling needs a change.
- Common decode at the sample event:
  - 1110 → slot 0, 1101 → slot 1, 1011 → slot 2, 0111 → slot 3.
  - 1111 (all off) → ignored, no error.
  - Any other pattern → com_err pulse at sample+1; capture mask cleared.
- Segment decode on fnd_data[6:0]:
  - 40 → 0, 79 → 1, 24 → 2, 30 → 3, 19 → 4, 12 → 5, 02 → 6, 78 → 7, 00 → 8, 10 → 9.
  - 7F → digit 0 with the blank flag set.
  - Any other pattern → digit_err pulse at sample+1; capture mask cleared; slot not written.
- Valid sample: the slot's digit, blank flag and dp flag are written, and the mask bit is set.
  - Re-sampling an already-captured slot overwrites it; the mask is unchanged.
- FSM: IDLE → CONV → DONE → IDLE.
  - IDLE: when mask = 1111, snapshot the four digits, blank flags and dp flags, clear the mask, acc = 0, go to CONV. Sampling continues into the cleared mask.
  - CONV: 4 cycles, slot 3 down to slot 0, each cycle acc = acc*10 + digit.
    - acc is 14 bits; the maximum 9999 never overflows.
    - Implement *10 as shift-add; no divider.
  - DONE: value = acc; blank_mask and dp_mask take the snapshot; value_valid = 1 for this cycle only. Next state IDLE.
- Latency: if the fourth slot is sampled at edge s, value/value_valid update at edge s+5.
- SETTLE_CYCLES ≥ 2 guarantees the mask cannot refill during CONV, so no frame is lost.
- Simultaneous events:
  - An illegal sample that coincides with the mask completing: the error takes priority, the mask clears, and CONV does not start.
  - An error that coincides with DONE: both pulses are issued, and value is still updated from the snapshot.
- Outputs hold their last values between frames.

Test Plan:
1. Reset, then scan display 1234 with each pair held 8 cycles: (1110, 99), (1101, B0), (1011, A4), (0111, F9) → value = 1234 at 4th sample + 5, one value_valid pulse, blank_mask = 0000, dp_mask = 0000.
2. Continuous scanning of 0, 9999 and 0507 (thousands blank, fnd_data = FF) → values 0, 9999 and 507 in order; blank_mask = 1000 for the 0507 frame; exactly one pulse per full scan.
3. Pair held only SETTLE_CYCLES−1 cycles, with glitches between digits → no sample for that pair; value is unchanged until a properly held frame completes.
4. Segment code 0xFE on slot 2 mid-frame → digit_err pulse; the subsequent clean 4-digit scan of 4321 yields value = 4321; partial digits from before the error are not merged.
5. fnd_com = 1100 held 8 cycles → com_err pulse, mask cleared; fnd_com = 1111 held → no error, no sample; dp on slot 1 (data 0x30 for digit 3) → dp_mask = 0010.
6. Assert rst during CONV of 8888 → no value_valid, all outputs 0; after release, a full scan of 0042 yields value = 42.
